// File: rtl/lfsr_checker.sv
// lfsr_checker: tracks a 26-bit Galois LFSR stream, locks/unlocks, counts mismatches (optional err_sticky via LFSR_CHK_STICKY_EN)
module lfsr_checker #(
  parameter int              N        = 26,
  parameter logic [N-1:0]    TAPS     = 26'h0000047,
  parameter int              LOCK_CNT = 8,
  parameter int              LOSS_CNT = 4,
  parameter int              CW       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [N-1:0]  i_d,
  input  logic          i_clr_cnt,
  output logic          o_locked,
  output logic          o_err,
  output logic          o_zero_det,
`ifdef LFSR_CHK_STICKY_EN
  output logic          o_err_sticky,
`endif
  output logic [CW-1:0] o_err_cnt
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BMAX = BW'(LOSS_CNT - 1);
  typedef enum logic [1:0] {PRIME, HUNT, LOCKED} state_t;
  state_t        r_state, w_state;
  logic [N-1:0]  r_prev, w_prev, w_step;
  logic [GW-1:0] r_good, w_good;
  logic [BW-1:0] r_bad, w_bad;
  logic [CW-1:0] r_err_cnt, w_err_cnt;
  logic          r_err, w_err, r_zero, w_zero, w_dz, w_good_step;
  assign w_step      = {r_prev[N-2:0], 1'b0} ^ (TAPS & {N{r_prev[N-1]}});
  assign w_dz        = (i_d == '0);
  assign w_good_step = (i_d == w_step) && !w_dz;
  assign o_locked    = (r_state == LOCKED);
  assign o_err       = r_err;
  assign o_zero_det  = r_zero;
  assign o_err_cnt   = r_err_cnt;
  // next-state: lock FSM, run counters, pulses and saturating error count
  always_comb begin
    w_state   = r_state;
    w_good    = r_good;
    w_bad     = r_bad;
    w_err_cnt = r_err_cnt;
    w_err     = 1'b0;
    w_zero    = 1'b0;
    w_prev    = i_en ? i_d : r_prev;
    if (i_en) begin
      w_zero = w_dz;
      case (r_state)
        PRIME: w_state = HUNT;
        HUNT: begin
          w_good  = (w_good_step && r_good != GMAX) ? r_good + 1'b1 : '0;
          w_state = (w_good_step && r_good == GMAX) ? LOCKED : HUNT;
        end
        LOCKED: begin
          w_err     = !w_good_step;
          w_err_cnt = (w_good_step || &r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
          w_bad     = (w_good_step || r_bad == BMAX) ? '0 : r_bad + 1'b1;
          w_state   = (!w_good_step && r_bad == BMAX) ? HUNT : LOCKED;
          w_good    = '0;
        end
        default: w_state = PRIME;
      endcase
    end
    if (i_clr_cnt) w_err_cnt = '0;
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= PRIME;
      r_prev    <= '0;
      r_good    <= '0;
      r_bad     <= '0;
      r_err     <= 1'b0;
      r_zero    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_prev    <= w_prev;
      r_good    <= w_good;
      r_bad     <= w_bad;
      r_err     <= w_err;
      r_zero    <= w_zero;
      r_err_cnt <= w_err_cnt;
    end
  end
`ifdef LFSR_CHK_STICKY_EN
  logic r_sticky;
  assign o_err_sticky = r_sticky;
  // sticky error flag: a new error wins over a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sticky <= 1'b0;
    else          r_sticky <= w_err ? 1'b1 : (i_clr_cnt ? 1'b0 : r_sticky);
  end
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lock, loss, error counting, zero detect and reset
module tb_lfsr_checker;
  localparam logic [25:0] TAPS = 26'h0000047;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [25:0] d = '0;
  logic        clr = 1'b0;
  logic        locked, err, zero_det, locked2, err2, zero2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [25:0] pv = '0;
  int          passed = 0;
  int          total = 0;
`ifdef LFSR_CHK_STICKY_EN
  logic        sticky, sticky2;
`endif

  lfsr_checker u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_d(d), .i_clr_cnt(clr),
    .o_locked(locked), .o_err(err), .o_zero_det(zero_det),
`ifdef LFSR_CHK_STICKY_EN
    .o_err_sticky(sticky),
`endif
    .o_err_cnt(cnt)
  );

  lfsr_checker #(.CW(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_d(d), .i_clr_cnt(clr),
    .o_locked(locked2), .o_err(err2), .o_zero_det(zero2),
`ifdef LFSR_CHK_STICKY_EN
    .o_err_sticky(sticky2),
`endif
    .o_err_cnt(cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] nxt(input logic [25:0] p);
    logic [25:0] n;
    for (int i = 0; i < 26; i++) n[i] = (i == 0 ? 1'b0 : p[i-1]) ^ (TAPS[i] & p[25]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic put(input logic [25:0] v, input logic c = 1'b0);
    @(negedge clk);
    en = 1'b1;
    d = v;
    clr = c;
    @(posedge clk);
    #1;
    en = 1'b0;
    clr = 1'b0;
    pv = v;
  endtask

  task automatic good();
    put(nxt(pv));
  endtask

  task automatic bad(input logic c = 1'b0);
    put(nxt(pv) ^ 26'h0000100, c);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_zero", zero_det, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // T1: true run from seed 1, lock appears after the 9th sample
    for (int i = 1; i <= 10; i++) begin
      put(26'h1 << (i - 1));
      chk("t1_locked", locked, (i >= 9) ? 1 : 0);
      chk("t1_err", err, 0);
      chk("t1_cnt", cnt, 0);
    end
    for (int i = 10; i <= 25; i++) put(26'h1 << i);
    chk("t2_locked_pre", locked, 1);
    chk("t2_err_pre", err, 0);
    // T2: 2000000 -> 46 is a mismatch while locked
    put(26'h0000046);
    chk("t2_mis_err", err, 1);
    chk("t2_mis_cnt", cnt, 1);
    chk("t2_mis_locked", locked, 1);
    good();
    chk("t2_err_onecycle", err, 0);
    chk("t2_cnt_hold", cnt, 1);
    // T3: clear, three bad then good keeps lock; four bad drops it
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t3_clr", cnt, 0);
    repeat (3) begin
      bad();
      chk("t3_err", err, 1);
    end
    good();
    chk("t3_cnt3", cnt, 3);
    chk("t3_still_locked", locked, 1);
    for (int i = 1; i <= 4; i++) begin
      bad();
      chk("t3_loss", locked, (i < 4) ? 1 : 0);
    end
    chk("t3_cnt7", cnt, 7);
    // relock; zero in HUNT pulses zero_det without err
    put(26'h0);
    chk("hunt_zero", zero_det, 1);
    chk("hunt_zero_err", err, 0);
    for (int i = 17; i <= 25; i++) begin
      put(26'h1 << i);
      chk("relock", locked, (i == 25) ? 1 : 0);
    end
    // T2 match: 2000000 -> 47 while locked
    put(26'h0000047);
    chk("t2_match_err", err, 0);
    chk("t2_match_locked", locked, 1);
    chk("t2_match_cnt", cnt, 7);
    // T4: 20 idle cycles with garbage on d
    repeat (20) begin
      @(negedge clk);
      d = 26'($urandom);
      @(posedge clk);
      #1;
      chk("t4_err", err, 0);
      chk("t4_zero", zero_det, 0);
    end
    chk("t4_locked", locked, 1);
    chk("t4_cnt", cnt, 7);
    good();
    chk("t4_resume_locked", locked, 1);
    chk("t4_resume_err", err, 0);
    chk("t4_nz_zero", zero_det, 0);
    // T5: zeros while locked are errors; lock is lost after four
    for (int i = 1; i <= 4; i++) begin
      put(26'h0);
      chk("t5_zero", zero_det, 1);
      chk("t5_err", err, 1);
      chk("t5_locked", locked, (i < 4) ? 1 : 0);
    end
    chk("t5_cnt", cnt, 11);
    repeat (12) begin
      put(26'h0);
      chk("t5_hunt_zero", zero_det, 1);
      chk("t5_hunt_err", err, 0);
      chk("t5_hunt_locked", locked, 0);
    end
    // T6: saturation on the CW=2 instance
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t6_clr2", cnt2, 0);
    for (int i = 0; i <= 9; i++) put(26'h1 << i);
    chk("t6_locked", locked, 1);
    bad(); bad(); bad();
    chk("t6_sat3", cnt2, 3);
    good();
    bad();
    chk("t6_sat4", cnt2, 3);
    bad();
    chk("t6_sat5", cnt2, 3);
    chk("t6_cnt5", cnt, 5);
    chk("t6_locked5", locked, 1);
    bad(1'b1);
    chk("t6_clr_err", err, 1);
    chk("t6_clr_cnt", cnt, 0);
    chk("t6_clr_cnt2", cnt2, 0);
    good();
    bad();
    chk("t6_pre_rst_err", err, 1);
    chk("t6_pre_rst_locked", locked, 1);
    chk("t6_pre_rst_cnt", cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err", err, 0);
    chk("async_cnt", cnt, 0);
    chk("async_cnt2", cnt2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      put(26'h1 << i);
      chk("recover", locked, (i >= 8) ? 1 : 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
